branch_cmp_ctrl: RTL
====================

# branch_cmp_ctrl

Branch resolution controller for the EX stage. It accepts one branch at a time from ID/EX and requests the shared ALU compare path through a request/grant handshake with the EX arbiter. It drives the ALU with the correct ALUFun and operands, samples the compare result, and issues a one-cycle PC redirect and flush when the branch is taken. It also provides starvation escalation and wrap-around branch statistics.

## Interface

Parameters:
- STARVE_LIMIT, 8: number of consecutive ungranted REQ cycles before `alu_prio` asserts.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- br_valid  in  1  branch offered by ID/EX.
- br_ready  out  1  controller can accept a branch.
- br_op  in  3  branch kind: 0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ, 6 BLT, 7 BLTU.
- br_rs, br_rt  in  32  operand values.
- br_pc  in  32  PC+4 of the branch.
- br_imm  in  16  signed word offset.
- kill  in  1  cancels any in-flight branch (older exception).
- alu_req  out  1  request for the shared ALU.
- alu_gnt  in  1  grant from the EX arbiter.
- alu_prio  out  1  starvation escalation to the arbiter.
- alu_a, alu_b  out  32  ALU operands.
- alu_fun  out  6  ALUFun.
- alu_sign  out  1  signed compare select.
- alu_s  in  1  compare result, valid the cycle after grant.
- redirect_valid  out  1  one-cycle taken-branch pulse.
- redirect_pc  out  32  branch target.
- flush  out  1  one-cycle IF/ID flush, coincident with `redirect_valid`.
- cnt_total, cnt_taken  out  CNT_W  resolved and taken branch counts.

## Operation

- FSM states: IDLE, REQ, WAIT.
  - IDLE: `br_ready = ~kill`. When `br_valid & br_ready`, latch op, rs, rt, pc, imm and go to REQ.
  - REQ: `alu_req = 1`, and `alu_a/b/fun/sign` are driven from the latched fields. When `alu_gnt` is high, go to WAIT.
  - WAIT: sample `alu_s` and resolve, then go to IDLE.
- `kill` in REQ or WAIT forces IDLE. A killed branch produces no redirect and is not counted. `kill` takes priority over `alu_gnt` and `alu_s` in the same cycle.
- `alu_fun` per op:
  - BEQ: 110011.
  - BNE: 110001.
  - BLT and BLTU: 110101.
  - BLTZ and BGEZ: 111010.
  - BLEZ: 111100.
  - BGTZ: 111110.
- `alu_b` is rt for BEQ, BNE, BLT and BLTU, and 0 otherwise.
- `alu_sign` is 0 only for BLTU.
- Outside REQ, `alu_a`, `alu_b`, `alu_fun` and `alu_sign` are 0.
- Taken = `alu_s`, except BGEZ where taken = `~alu_s`.
- Target = `br_pc + {{14{imm[15]}}, imm, 2'b00}`, computed mod 2^32 (wraps silently).
- Starvation counter:
  - Cleared on entering REQ and on grant.
  - Increments each ungranted REQ cycle and saturates at STARVE_LIMIT.
  - `alu_prio = (state == REQ) & (cnt == STARVE_LIMIT)`.
- Statistics, on each non-killed resolve:
  - `cnt_total` increments.
  - `cnt_taken` increments if taken.
  - Both wrap from all-ones to 0.

## Timing

- Reset values: state IDLE, and 0 on every output register.
  - `br_ready` is 1 once reset is released (it is 0 during reset).
  - `alu_req`, `alu_prio`, `redirect_valid`, `flush`, `redirect_pc`, `cnt_total` and `cnt_taken` are all 0.
- Reset asserted mid-operation aborts immediately: no redirect, counters cleared.
- Accept at edge E0. REQ occupies cycle 1. If granted in cycle 1, WAIT is cycle 2 and `alu_s` is sampled at edge E2.
- `redirect_valid`, `flush` and `redirect_pc` are registered and visible in cycle 3 for exactly one cycle.
- `br_ready` is high again in cycle 3. Minimum accept-to-accept interval is 3 cycles.
- `alu_gnt` is ignored outside REQ. `alu_s` is ignored outside WAIT.
- `redirect_pc` holds its last value when `redirect_valid = 0`.
- `br_valid` while `br_ready = 0` is not accepted; the producer must hold it.

## Test plan

- BEQ, rs = rt = 0x1234, pc = 0x100, imm = 0x0004, gnt in cycle 1, alu_s = 1:
  - `alu_fun = 110011` in REQ.
  - `redirect_valid` and `flush` high in cycle 3 with `redirect_pc = 0x110`.
  - `cnt_total = 1`, `cnt_taken = 1`.
- BGEZ, alu_s = 1: no redirect; `cnt_total` increments, `cnt_taken` unchanged. With alu_s = 0: redirect taken.
- BLTU, imm = 0xFFFF, pc = 0x0000_0000, taken:
  - `alu_sign = 0`, `alu_b = rt`.
  - `redirect_pc = 0xFFFF_FFFC` (wrap).
- gnt withheld for 10 cycles with STARVE_LIMIT = 8:
  - `alu_prio` rises on the 9th REQ cycle and stays high until grant.
  - It drops the cycle after grant; then resolves normally.
- `kill` in WAIT with alu_s = 1: no redirect, counters unchanged, `br_ready` = 1 next cycle.
- Reset pulsed while in REQ: `alu_req` is 0 asynchronously, counters are 0, and the next branch resolves normally. Separately, preset counters to all-ones and resolve one taken branch: both counters wrap to 0.

Source files
------------

// File: rtl/branch_cmp_ctrl_if.sv
// Shared ALU compare-path bus between the branch controller and the EX arbiter.
//   master (branch controller): drives alu_req, alu_prio, alu_a, alu_b,
//                               alu_fun, alu_sign; receives alu_gnt, alu_s
//   slave  (arbiter / ALU side): the mirror image
//   alu_req   request for the shared ALU
//   alu_gnt   grant from the EX arbiter
//   alu_prio  starvation escalation
//   alu_a/b   32-bit operands
//   alu_fun   6-bit ALUFun
//   alu_sign  signed compare select
//   alu_s     compare result, valid the cycle after grant
interface branch_cmp_ctrl_if;
  logic        alu_req;
  logic        alu_gnt;
  logic        alu_prio;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_fun;
  logic        alu_sign;
  logic        alu_s;

  modport master (
    output alu_req, alu_prio, alu_a, alu_b, alu_fun, alu_sign,
    input  alu_gnt, alu_s
  );

  modport slave (
    input  alu_req, alu_prio, alu_a, alu_b, alu_fun, alu_sign,
    output alu_gnt, alu_s
  );
endinterface

// File: rtl/branch_cmp_ctrl.sv
// Branch resolution controller for the EX stage. Accepts one branch at a
// time, borrows the shared ALU compare path through a request/grant
// handshake, resolves the branch and issues a one-cycle redirect + flush
// when taken. Also escalates priority when starved and keeps wrap-around
// branch statistics.
// Ports:
//   clk             system clock, rising edge
//   reset           asynchronous, active-low reset
//   br_valid/ready  branch offer from ID/EX and accept indication
//   br_op           branch kind (BEQ,BNE,BLEZ,BGTZ,BLTZ,BGEZ,BLT,BLTU)
//   br_rs/br_rt     operand values
//   br_pc           PC+4 of the branch
//   br_imm          signed word offset
//   kill            cancels any in-flight branch
//   alu             shared ALU bus (master side)
//   redirect_valid  one-cycle taken-branch pulse
//   redirect_pc     branch target (holds when not redirecting)
//   flush           one-cycle IF/ID flush, coincident with redirect_valid
//   cnt_total       resolved branch count (wraps)
//   cnt_taken       taken branch count (wraps)
module branch_cmp_ctrl #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 br_valid,
  output logic                 br_ready,
  input  logic [2:0]           br_op,
  input  logic [31:0]          br_rs,
  input  logic [31:0]          br_rt,
  input  logic [31:0]          br_pc,
  input  logic [15:0]          br_imm,
  input  logic                 kill,
  branch_cmp_ctrl_if.master    alu,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 flush,
  output logic [CNT_W-1:0]     cnt_total,
  output logic [CNT_W-1:0]     cnt_taken
);

  localparam logic [2:0] OP_BEQ  = 3'd0;
  localparam logic [2:0] OP_BNE  = 3'd1;
  localparam logic [2:0] OP_BLEZ = 3'd2;
  localparam logic [2:0] OP_BGTZ = 3'd3;
  localparam logic [2:0] OP_BLTZ = 3'd4;
  localparam logic [2:0] OP_BGEZ = 3'd5;
  localparam logic [2:0] OP_BLT  = 3'd6;
  localparam logic [2:0] OP_BLTU = 3'd7;

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state, state_nxt;
  logic          accept;
  logic          resolve;
  logic          taken;
  logic [31:0]   target;
  logic [2:0]    op_q;
  logic [31:0]   rs_q, rt_q, pc_q;
  logic [15:0]   imm_q;
  logic [SW-1:0] starve_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. Kill beats grant and compare result in the same cycle.
  // br_ready is also gated by reset so it reads 0 while reset is held.
  always_comb begin
    state_nxt = state;
    br_ready  = 1'b0;
    accept    = 1'b0;
    resolve   = 1'b0;
    case (state)
      IDLE: begin
        br_ready = ~kill & reset;
        if (br_valid & ~kill) begin
          accept    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (kill)             state_nxt = IDLE;
        else if (alu.alu_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        state_nxt = IDLE;
        if (!kill) resolve = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Branch fields captured at accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q  <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      pc_q  <= '0;
      imm_q <= '0;
    end else if (accept) begin
      op_q  <= br_op;
      rs_q  <= br_rs;
      rt_q  <= br_rt;
      pc_q  <= br_pc;
      imm_q <= br_imm;
    end
  end

  // Starvation counter: restarts on every new request and on grant,
  // saturates so alu_prio stays up until the arbiter relents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q <= '0;
    end else if (accept || (state == REQ && alu.alu_gnt)) begin
      starve_q <= '0;
    end else if (state == REQ && starve_q != STARVE_MAX) begin
      starve_q <= starve_q + SW'(1);
    end
  end

  // ALU drive: only meaningful while requesting, zero otherwise.
  // Zero-compare ops use B = 0 so the ALU compares rs against zero.
  always_comb begin
    alu.alu_req  = 1'b0;
    alu.alu_prio = 1'b0;
    alu.alu_a    = '0;
    alu.alu_b    = '0;
    alu.alu_fun  = '0;
    alu.alu_sign = 1'b0;
    if (state == REQ) begin
      alu.alu_req  = 1'b1;
      alu.alu_prio = (starve_q == STARVE_MAX);
      alu.alu_a    = rs_q;
      alu.alu_sign = (op_q != OP_BLTU);
      if (op_q == OP_BEQ || op_q == OP_BNE || op_q == OP_BLT || op_q == OP_BLTU)
        alu.alu_b = rt_q;
      case (op_q)
        OP_BEQ:          alu.alu_fun = 6'b110011;
        OP_BNE:          alu.alu_fun = 6'b110001;
        OP_BLT, OP_BLTU: alu.alu_fun = 6'b110101;
        OP_BLTZ, OP_BGEZ: alu.alu_fun = 6'b111010;
        OP_BLEZ:         alu.alu_fun = 6'b111100;
        OP_BGTZ:         alu.alu_fun = 6'b111110;
        default:         alu.alu_fun = 6'b000000;
      endcase
    end
  end

  // BGEZ shares the less-than-zero compare, so its sense is inverted.
  assign taken  = (op_q == OP_BGEZ) ? ~alu.alu_s : alu.alu_s;
  assign target = pc_q + {{14{imm_q[15]}}, imm_q, 2'b00};

  // Redirect/flush pulse; redirect_pc only moves on a taken branch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= resolve & taken;
      flush          <= resolve & taken;
      if (resolve & taken) redirect_pc <= target;
    end
  end

  // Statistics, wrapping naturally at the counter width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_total <= '0;
      cnt_taken <= '0;
    end else if (resolve) begin
      cnt_total <= cnt_total + CNT_W'(1);
      if (taken) cnt_taken <= cnt_taken + CNT_W'(1);
    end
  end

endmodule
